// File: rtl/key_filter_pkg.sv
// Shared definitions for the key_filter push-button conditioner.
//   key_state_t         : 2-bit debounce FSM state encoding
//   DB_CYCLES_DEFAULT   : default debounce length (20 ms at 100 MHz)
//   LONG_CYCLES_DEFAULT : default long-press length (1 s at 100 MHz)
//   DB_CNT_W / HOLD_CNT_W : counter widths covering the legal parameter ranges
package key_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } key_state_t;

  localparam int unsigned DB_CYCLES_DEFAULT   = 2000000;
  localparam int unsigned LONG_CYCLES_DEFAULT = 100000000;

  localparam int DB_CNT_W   = 24;
  localparam int HOLD_CNT_W = 27;

endpackage

// File: rtl/key_filter_if.sv
// Key signal bundle between the raw button source and the filter.
//   key_i       : raw push-button level (1 = pressed), may bounce
//   key_level   : debounced level
//   key_press   : one-cycle pulse on accepted press
//   key_release : one-cycle pulse on accepted release
//   key_long    : one-cycle pulse on long hold
// Modports: slave = the filter, master = the button source / consumer side.
interface key_filter_if;
  logic key_i;
  logic key_level;
  logic key_press;
  logic key_release;
  logic key_long;

  modport slave (
    input  key_i,
    output key_level,
    output key_press,
    output key_release,
    output key_long
  );

  modport master (
    output key_i,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_long
  );
endinterface

// File: rtl/key_filter_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk  : destination clock
//   srst : synchronous active-high reset, clears both flops to 0
//   d    : asynchronous input
//   q    : synchronized output (second flop)
module sync_2ff (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/key_filter.sv
// Push-button debouncer with press/release/long-press pulse outputs.
//   System_clk : single clock, all logic on its rising edge
//   rst        : synchronous active-high reset
//   key_bus    : key_filter_if.slave (key_i in; key_level, key_press,
//                key_release, key_long out; all outputs registered)
// Parameters: DB_CYCLES (stable samples to accept a level change),
//             LONG_CYCLES (cycles in HELD before key_long).
// Optional feature: define KEY_FILTER_LONG_PRESS_EN to build the hold
// counter; otherwise key_long is tied to 0.
module key_filter
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEFAULT
) (
  input  logic         System_clk,
  input  logic         rst,
  key_filter_if.slave  key_bus
);

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic key_s;

  sync_2ff u_sync (
    .clk  (System_clk),
    .srst (rst),
    .d    (key_bus.key_i),
    .q    (key_s)
  );

  key_state_t          state_reg, state_next;
  logic [DB_CNT_W-1:0] db_cnt_reg, db_cnt_next;
  logic                level_reg, level_next;
  logic                press_reg, press_next;
  logic                release_reg, release_next;

  // The counter only advances while the sampled level agrees with the
  // pending change; reaching DB_LAST means DB_CYCLES consecutive agreeing
  // samples, so it stops there and never wraps.
  always_comb begin
    state_next   = state_reg;
    db_cnt_next  = db_cnt_reg;
    level_next   = level_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (key_s) begin
          state_next  = PRESS_CHK;
          db_cnt_next = '0;
        end
      end
      PRESS_CHK: begin
        if (!key_s) begin
          state_next = IDLE;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next = HELD;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end
      HELD: begin
        if (!key_s) begin
          state_next  = REL_CHK;
          db_cnt_next = '0;
        end
      end
      REL_CHK: begin
        if (key_s) begin
          state_next = HELD;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next   = IDLE;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge System_clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      db_cnt_reg  <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      db_cnt_reg  <= db_cnt_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  assign key_bus.key_level   = level_reg;
  assign key_bus.key_press   = press_reg;
  assign key_bus.key_release = release_reg;

`ifdef KEY_FILTER_LONG_PRESS_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_CNT_W-1:0] HOLD_SAT  = HOLD_CNT_W'(LONG_CYCLES);

  logic [HOLD_CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic                  long_reg, long_next;

  // Cleared only on a fresh press; REL_CHK leaves it untouched so a
  // rejected release glitch resumes the count. Parking at HOLD_SAT
  // guarantees a single pulse per press.
  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    long_next     = 1'b0;
    if (state_reg == PRESS_CHK && state_next == HELD) begin
      hold_cnt_next = '0;
    end else if (state_reg == HELD && hold_cnt_reg != HOLD_SAT) begin
      if (hold_cnt_reg == HOLD_LAST) begin
        long_next = 1'b1;
      end
      hold_cnt_next = hold_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge System_clk) begin
    if (rst) begin
      hold_cnt_reg <= '0;
      long_reg     <= 1'b0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      long_reg     <= long_next;
    end
  end

  assign key_bus.key_long = long_reg;
`else
  assign key_bus.key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_filter.sv
// Directed testbench for key_filter with DB_CYCLES=4, LONG_CYCLES=10.
// Cycle n = the sample taken just after the n-th rising edge of a scenario;
// a key_i value applied in iteration n is first seen at that edge.
module tb_key_filter;

  logic clk;
  logic rst;
  int   checks;
  int   passed;
  int   overlap_seen;
  int   long_exp;

  key_filter_if kbus ();

  key_filter #(
    .DB_CYCLES   (4),
    .LONG_CYCLES (10)
  ) dut (
    .System_clk (clk),
    .rst        (rst),
    .key_bus    (kbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_cycle(input logic k, input logic r);
    kbus.key_i = k;
    rst        = r;
    @(posedge clk);
    #1;
    if (kbus.key_press && kbus.key_release) overlap_seen++;
  endtask

  task automatic apply_reset();
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    int press_at;
    press_at = -1;
    // key held during reset: outputs stay 0, then it counts as a new press
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1);
    checks++; if (kbus.key_level !== 1'b0) $display("FAIL reset_level: got %b expected 0", kbus.key_level); else passed++;
    checks++; if (kbus.key_press !== 1'b0) $display("FAIL reset_press: got %b expected 0", kbus.key_press); else passed++;
    checks++; if (kbus.key_release !== 1'b0) $display("FAIL reset_release: got %b expected 0", kbus.key_release); else passed++;
    checks++; if (kbus.key_long !== 1'b0) $display("FAIL reset_long: got %b expected 0", kbus.key_long); else passed++;
    for (int c = 0; c < 12; c++) begin
      run_cycle(1'b1, 1'b0);
      if (kbus.key_press && press_at < 0) press_at = c;
    end
    checks++; if (press_at !== 6) $display("FAIL held_through_reset_press_cycle: got %0d expected 6", press_at); else passed++;
    $display("test_reset: press after reset release at cycle %0d", press_at);
  endtask

  task automatic test_clean_press();
    int   press_n, press_at, rel_n, rel_at, long_n;
    logic lvl5, lvl6, lvl26;
    press_n = 0; press_at = -1; rel_n = 0; rel_at = -1; long_n = 0;
    lvl5 = 1'bx; lvl6 = 1'bx; lvl26 = 1'bx;
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      run_cycle(c < 20, 1'b0);
      if (kbus.key_press) begin press_n++; if (press_at < 0) press_at = c; end
      if (kbus.key_release) begin rel_n++; if (rel_at < 0) rel_at = c; end
      if (kbus.key_long) long_n++;
      if (c == 5) lvl5 = kbus.key_level;
      if (c == 6) lvl6 = kbus.key_level;
      if (c == 26) lvl26 = kbus.key_level;
    end
    checks++; if (press_at !== 6) $display("FAIL clean_press_cycle: got %0d expected 6", press_at); else passed++;
    checks++; if (press_n !== 1) $display("FAIL clean_press_count: got %0d expected 1", press_n); else passed++;
    checks++; if (lvl5 !== 1'b0) $display("FAIL clean_level_c5: got %b expected 0", lvl5); else passed++;
    checks++; if (lvl6 !== 1'b1) $display("FAIL clean_level_c6: got %b expected 1", lvl6); else passed++;
    checks++; if (rel_at !== 26) $display("FAIL clean_release_cycle: got %0d expected 26", rel_at); else passed++;
    checks++; if (rel_n !== 1) $display("FAIL clean_release_count: got %0d expected 1", rel_n); else passed++;
    checks++; if (lvl26 !== 1'b0) $display("FAIL clean_level_c26: got %b expected 0", lvl26); else passed++;
    checks++; if (long_n !== long_exp) $display("FAIL clean_long_count: got %0d expected %0d", long_n, long_exp); else passed++;
    $display("test_clean_press: press@%0d release@%0d long_pulses=%0d", press_at, rel_at, long_n);
  endtask

  task automatic test_bounce();
    int press_n, press_at, rel_n;
    logic pat [0:3];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
    press_n = 0; press_at = -1; rel_n = 0;
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      run_cycle((c < 4) ? pat[c] : 1'b1, 1'b0);
      if (kbus.key_press) begin press_n++; if (press_at < 0) press_at = c; end
    end
    for (int c = 0; c < 15; c++) begin
      run_cycle(1'b0, 1'b0);
      if (kbus.key_release) rel_n++;
    end
    checks++; if (press_n !== 1) $display("FAIL bounce_press_count: got %0d expected 1", press_n); else passed++;
    checks++; if (press_at !== 10) $display("FAIL bounce_press_cycle: got %0d expected 10", press_at); else passed++;
    checks++; if (rel_n !== 1) $display("FAIL bounce_release_count: got %0d expected 1", rel_n); else passed++;
    $display("test_bounce: press@%0d presses=%0d releases=%0d", press_at, press_n, rel_n);
  endtask

  task automatic test_release_bounce();
    int rel_n, low_after, long_at;
    rel_n = 0; low_after = 0; long_at = -1;
    apply_reset();
    for (int c = 0; c < 30; c++) begin
      run_cycle(!(c == 12 || c == 13), 1'b0);
      if (kbus.key_release) rel_n++;
      if (c >= 6 && kbus.key_level !== 1'b1) low_after++;
      if (kbus.key_long && long_at < 0) long_at = c;
    end
    checks++; if (rel_n !== 0) $display("FAIL glitch_release_count: got %0d expected 0", rel_n); else passed++;
    checks++; if (low_after !== 0) $display("FAIL glitch_level_drops: got %0d expected 0", low_after); else passed++;
    // hold count frozen for two REL_CHK cycles, so long lands at 18, not 16
    checks++; if (long_at !== ((long_exp == 1) ? 18 : -1)) $display("FAIL glitch_long_cycle: got %0d expected %0d", long_at, (long_exp == 1) ? 18 : -1); else passed++;
    $display("test_release_bounce: releases=%0d level_drops=%0d long@%0d", rel_n, low_after, long_at);
  endtask

  task automatic test_reset_mid_debounce();
    int press_n, press_at;
    press_n = 0; press_at = -1;
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      run_cycle(1'b1, c == 4);
      if (kbus.key_press) begin press_n++; if (press_at < 0) press_at = c; end
    end
    checks++; if (press_at !== 11) $display("FAIL rst_mid_press_cycle: got %0d expected 11", press_at); else passed++;
    checks++; if (press_n !== 1) $display("FAIL rst_mid_press_count: got %0d expected 1", press_n); else passed++;
    $display("test_reset_mid_debounce: press@%0d presses=%0d", press_at, press_n);
  endtask

  task automatic test_long();
    int long_n, long_at, press_at;
    long_n = 0; long_at = -1; press_at = -1;
    apply_reset();
    for (int c = 0; c < 36; c++) begin
      run_cycle(c < 30, 1'b0);
      if (kbus.key_press && press_at < 0) press_at = c;
      if (kbus.key_long) begin long_n++; if (long_at < 0) long_at = c; end
    end
    checks++; if (long_n !== long_exp) $display("FAIL long_count: got %0d expected %0d", long_n, long_exp); else passed++;
    checks++; if (long_at !== ((long_exp == 1) ? 16 : -1)) $display("FAIL long_cycle: got %0d expected %0d", long_at, (long_exp == 1) ? 16 : -1); else passed++;
    $display("test_long: press@%0d long@%0d long_pulses=%0d", press_at, long_at, long_n);
  endtask

  task automatic test_back_to_back();
    int        shift_pulses;
    logic [7:0] shift_reg;
    shift_pulses = 0; shift_reg = 8'h00;
    apply_reset();
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 20; c++) begin
        run_cycle(c < 10, 1'b0);
        if (kbus.key_press) begin
          shift_pulses++;
          shift_reg = {shift_reg[6:0], 1'b1};
        end
      end
    end
    for (int c = 0; c < 10; c++) run_cycle(1'b0, 1'b0);
    checks++; if (shift_pulses !== 6) $display("FAIL b2b_shift_pulses: got %0d expected 6", shift_pulses); else passed++;
    checks++; if (shift_reg !== 8'h3f) $display("FAIL b2b_shift_reg: got %h expected 3f", shift_reg); else passed++;
    checks++; if (overlap_seen !== 0) $display("FAIL press_release_overlap: got %0d expected 0", overlap_seen); else passed++;
    $display("test_back_to_back: shift_pulses=%0d shift_reg=%h", shift_pulses, shift_reg);
  endtask

  initial begin
    checks       = 0;
    passed       = 0;
    overlap_seen = 0;
`ifdef KEY_FILTER_LONG_PRESS_EN
    long_exp = 1;
`else
    long_exp = 0;
`endif
    kbus.key_i = 1'b0;
    rst        = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_reset_mid_debounce();
    test_long();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
